// File: rtl/toggle_meter_pkg.sv
// Shared FSM state type and default constants for the toggle period meter.
package toggle_meter_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    IDLE  = 2'd1,
    MEAS  = 2'd2
  } meter_state_e;

  localparam int unsigned CNT_W_DEF    = 25;
  localparam int unsigned EXP_HALF_DEF = 25_000_000;
  localparam int unsigned TOL_DEF      = 1_000;
  localparam int unsigned TIMEOUT_DEF  = 30_000_000;
  localparam int unsigned LOCK_CNT_DEF = 4;

  // Synchroniser fill time; an edge seen during this window is an artefact of reset.
  localparam int unsigned PRIME_CYCLES = 3;
  localparam int unsigned LOCK_W       = 4;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level plus a delay flop for toggle detection.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic level_o,
  output logic toggle_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o  = s2_q;
  assign toggle_o = s2_q ^ s3_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures sys_clk cycles between toggles of a slow asynchronous signal,
// checks each half-period against a tolerance window, and tracks lock / loss-of-signal.
module toggle_period_meter
  import toggle_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EXP_HALF    = EXP_HALF_DEF,
  parameter int unsigned TOL         = TOL_DEF,
  parameter int unsigned TIMEOUT_MAX = TIMEOUT_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  output logic             level,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             in_range,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_C      = CNT_W'(TIMEOUT_MAX);
  localparam logic [CNT_W:0]    EXP_C      = (CNT_W+1)'(EXP_HALF);
  localparam logic [CNT_W:0]    TOL_C      = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]    LEN_ONE    = (CNT_W+1)'(1);
  localparam logic [LOCK_W-1:0] LOCK_C     = LOCK_W'(LOCK_CNT);
  localparam logic [LOCK_W-1:0] LOCK_ONE   = LOCK_W'(1);

  meter_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              vld_q, vld_d;
  logic              inr_q, inr_d;
  logic              locked_q, locked_d;
  logic              tmo_q, tmo_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic              raw_toggle;
  logic              tog;
  logic [CNT_W:0]    meas_len;
  logic [CNT_W:0]    meas_dev;
  logic              meas_ok;

  sync_edge_det u_sync (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .sig_i    (sig_in),
    .level_o  (level),
    .toggle_o (raw_toggle)
  );

  assign tog = raw_toggle && (state_q != PRIME);

  // One extra bit keeps cnt+1 and the deviation free of wrap-around.
  assign meas_len = {1'b0, cnt_q} + LEN_ONE;
  assign meas_dev = (meas_len >= EXP_C) ? (meas_len - EXP_C) : (EXP_C - meas_len);
  assign meas_ok  = (meas_dev <= TOL_C);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRIME: if (cnt_q == PRIME_LAST) state_d = IDLE;
      IDLE:  if (tog) state_d = MEAS;
      MEAS:  if (!tog && (cnt_q == TMO_C)) state_d = IDLE;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    vld_d      = 1'b0;
    inr_d      = inr_q;
    locked_d   = locked_q;
    tmo_d      = 1'b0;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      PRIME: begin
        cnt_d = (cnt_q == PRIME_LAST) ? '0 : cnt_q + CNT_ONE;
      end
      IDLE: begin
        cnt_d = '0;
      end
      MEAS: begin
        // A toggle on the timeout cycle still counts as a valid measurement.
        if (tog) begin
          cnt_d    = '0;
          period_d = meas_len[CNT_W-1:0];
          vld_d    = 1'b1;
          inr_d    = meas_ok;
          if (meas_ok) begin
            if (lock_cnt_q != LOCK_C) lock_cnt_d = lock_cnt_q + LOCK_ONE;
            if (lock_cnt_d == LOCK_C) locked_d = 1'b1;
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else if (cnt_q == TMO_C) begin
          cnt_d      = '0;
          tmo_d      = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      inr_q      <= 1'b0;
      locked_q   <= 1'b0;
      tmo_q      <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      inr_q      <= inr_d;
      locked_q   <= locked_d;
      tmo_q      <= tmo_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign period_out = period_q;
  assign period_vld = vld_q;
  assign in_range   = inr_q;
  assign locked     = locked_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Self-checking bench: event-level reference model (edge timestamps and their
// differences) compared every cycle, plus directed literal checks.
module tb_toggle_period_meter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXP   = 10;
  localparam int unsigned TOLV  = 1;
  localparam int unsigned TMAX  = 20;
  localparam int unsigned LOCKN = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             level;
  logic [CNT_W-1:0] period_out;
  logic             period_vld;
  logic             in_range;
  logic             locked;
  logic             timeout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  toggle_period_meter #(
    .CNT_W       (CNT_W),
    .EXP_HALF    (EXP),
    .TOL         (TOLV),
    .TIMEOUT_MAX (TMAX),
    .LOCK_CNT    (LOCKN)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sig_in     (sig_in),
    .level      (level),
    .period_out (period_out),
    .period_vld (period_vld),
    .in_range   (in_range),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  function void chk(string name, logic [31:0] act, int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: sample history since reset, detected-edge timestamps,
  // spacing = difference of timestamps, timeout = too long since last edge.
  bit hist[$];
  bit m_live = 0;
  int m_j, m_last, m_streak, n;
  bit m_armed, det;
  bit m_level, m_vld, m_inr, m_locked, m_tmo;
  int m_period;

  always @(posedge sys_clk) begin
    cyc++;
    m_vld = 0;
    m_tmo = 0;
    if (!sys_rst_n) begin
      hist.delete();
      hist.push_back(1'b0);
      m_live = 1; m_j = 0; m_armed = 0; m_last = 0; m_streak = 0;
      m_level = 0; m_inr = 0; m_locked = 0; m_period = 0;
    end else if (m_live) begin
      m_j++;
      hist.push_back(sig_in);
      m_level = hist[m_j-1];
      // A toggle is recognised 3 samples after it is taken; the first 3 samples follow reset.
      det = (m_j >= 4) && (hist[m_j-2] != hist[m_j-3]);
      if (det) begin
        if (m_armed) begin
          n = m_j - m_last;
          m_vld = 1;
          m_period = n;
          m_inr = ((n >= int'(EXP)) ? n - int'(EXP) : int'(EXP) - n) <= int'(TOLV);
          m_streak = m_inr ? m_streak + 1 : 0;
          m_locked = (m_streak >= int'(LOCKN));
          $display("txn cycle=%0d period=%0d in_range=%0d locked=%0d", cyc, n, m_inr, m_locked);
        end else begin
          m_armed = 1;
        end
        m_last = m_j;
      end else if (m_armed && (m_j - m_last == int'(TMAX) + 1)) begin
        m_tmo = 1;
        m_armed = 0;
        m_streak = 0;
        m_locked = 0;
        $display("txn cycle=%0d timeout", cyc);
      end
    end
  end

  always @(negedge sys_clk) begin
    if (m_live) begin
      chk("level",      32'(level),      m_level);
      chk("period_vld", 32'(period_vld), m_vld);
      chk("period_out", 32'(period_out), m_period);
      chk("in_range",   32'(in_range),   m_inr);
      chk("locked",     32'(locked),     m_locked);
      chk("timeout",    32'(timeout),    m_tmo);
    end
  end

  // Toggle 'gap' cycles after the previous toggle, then check the result of its detection.
  task automatic tog(int gap, bit e_vld, int e_per, bit e_inr, bit e_lck);
    repeat (gap - 3) @(negedge sys_clk);
    sig_in = ~sig_in;
    repeat (3) @(negedge sys_clk);
    chk("lit_vld", 32'(period_vld), e_vld);
    if (e_vld) begin
      chk("lit_period", 32'(period_out), e_per);
      chk("lit_inr",    32'(in_range),   e_inr);
    end
    chk("lit_locked", 32'(locked), e_lck);
  endtask

  initial begin
    int gap, r;
    // 1: reset with sig_in high; the reset-time level must not look like an edge
    sig_in = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk); chk("lit_level0", 32'(level), 0);
    @(negedge sys_clk); chk("lit_level1", 32'(level), 1);
    repeat (48) @(negedge sys_clk);
    chk("lit_lock_init", 32'(locked), 0);

    // 2: steady 10-cycle toggling
    tog(10, 0, 0, 0, 0);
    tog(10, 1, 10, 1, 0);
    tog(10, 1, 10, 1, 1);
    tog(10, 1, 10, 1, 1);

    // 3: tolerance edges and relock
    tog(9,  1, 9,  1, 1);
    tog(11, 1, 11, 1, 1);
    tog(12, 1, 12, 0, 0);
    tog(10, 1, 10, 1, 0);
    tog(10, 1, 10, 1, 1);

    // 4: signal stops -> timeout 21 cycles after the last detection
    repeat (20) @(negedge sys_clk);
    chk("lit_tmo_early", 32'(timeout), 0);
    @(negedge sys_clk);
    chk("lit_tmo", 32'(timeout), 1);
    chk("lit_tmo_lock", 32'(locked), 0);
    tog(5,  0, 0, 0, 0);
    tog(10, 1, 10, 1, 0);

    // 5: longest reportable spacing, then one cycle longer
    tog(21, 1, 21, 0, 0);
    tog(22, 0, 0, 0, 0);

    // 6: reset mid-measurement while locked
    tog(10, 1, 10, 1, 0);
    tog(10, 1, 10, 1, 1);
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("lit_rst_lock",   32'(locked),     0);
    chk("lit_rst_period", 32'(period_out), 0);
    chk("lit_rst_inr",    32'(in_range),   0);
    chk("lit_rst_level",  32'(level),      0);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    tog(5,  0, 0, 0, 0);
    tog(10, 1, 10, 1, 0);

    // Randomised spacing, silences and occasional resets
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       gap = $urandom_range(9, 11);
      else if (r < 12) gap = $urandom_range(7, 13);
      else if (r < 16) gap = $urandom_range(19, 23);
      else if (r < 18) gap = $urandom_range(1, 30);
      else             gap = $urandom_range(30, 45);
      repeat (gap) @(negedge sys_clk);
      sig_in = ~sig_in;
      if ($urandom_range(0, 39) == 0) begin
        sys_rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge sys_clk);
        sys_rst_n = 1'b1;
      end
    end
    repeat (30) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
